wb_retire: RTL and testbench
============================

# wb_retire

In-order write-back retirement queue at the register-file write end of the pipeline. It buffers completed instruction results from EXE/MEM, waits for in-order load data from data memory, and retires one result per cycle onto the register-file write port (`wb_wb_en`/`wb_dest`/`wb_value`). It also owns the NZCV status register read by the ID-stage condition check, and reports read-after-write hazards against pending destinations back to ID.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EXE/MEM presents a result.
- `in_ready`  out  1  queue can accept; `count < DEPTH`; no same-cycle retire bypass.
- `in_wb_en`  in  1  result writes a register.
- `in_dest`  in  4  destination register 0–14.
- `in_mem_read`  in  1  load; value arrives later on `mem_rsp_*`.
- `in_value`  in  32  ALU result; ignored when `in_mem_read`=1.
- `in_s`  in  1  update status on retire; ignored for loads.
- `in_flags`  in  4  {n,z,c,v}.
- `mem_rsp_valid`  in  1  load data valid; loads complete in order.
- `mem_rsp_data`  in  32  load data.
- `hz_src1`, `hz_src2`  in  4  ID source registers.
- `hz_two_src`  in  1  `hz_src2` is live.
- `hazard`  out  1  pending write to a live source.
- `wb_wb_en`  out  1  register-file write strobe, one-cycle pulse.
- `wb_dest`  out  4  write address.
- `wb_value`  out  32  write data.
- `status`  out  4  {n,z,c,v} status register.
- `count`  out  clog2(DEPTH+1)  occupied entries.
- `rsp_err`  out  1  sticky; unmatched memory response.

## Operation
- Each entry is in one of three states: EMPTY, WAIT_MEM, or READY. The queue uses head, tail, and load pointers, which wrap modulo DEPTH.
- **Enqueue:** on `in_valid & in_ready`, write the tail entry and advance the tail. The entry goes to WAIT_MEM if `in_mem_read`=1, otherwise READY.
- **Memory response:** on `mem_rsp_valid`, the oldest WAIT_MEM entry (load pointer) captures the data, moves to READY, and the load pointer advances.
  - If no WAIT_MEM entry exists at the clock edge, the response is dropped and `rsp_err` is set until reset.
  - An entry enqueued in the same cycle is not yet visible to a response.
- **Retire:** if the head entry is READY, pop it. On that edge, `wb_wb_en` ← `entry.wb_en`, and `wb_dest`/`wb_value` ← the entry's fields. If `entry.s` is set and the entry is not a load, `status` ← `entry.flags`.
  - Entries with `wb_en`=0 still retire; this produces a zero strobe but can update status.
  - At most one retire per cycle. A head in WAIT_MEM blocks all younger entries.
- **Simultaneous events:**
  - Enqueue and retire in the same cycle: `count` is unchanged.
  - Response and retire in the same cycle act on different entries. A response to the head makes it READY only on the next edge.
- **Hazard (combinational):** `hazard` is 1 if any non-EMPTY entry with `wb_en`=1 has `dest == hz_src1`, or (`hz_two_src` and `dest == hz_src2`). The retired output register is excluded, because the register file writes on the falling edge before ID reads.
- **Reset (asserted at any time):** all entries become EMPTY, pointers go to 0, `count`=0, `wb_wb_en`=0, `wb_dest`=0, `wb_value`=0, `status`=0, `rsp_err`=0, `hazard`=0. Pending loads are discarded; responses arriving after reset set `rsp_err`.

## Timing
- **ALU result:** accepted at edge t, retired at edge t+1; `wb_wb_en` is high during cycle t+1 if the queue was empty.
- **Load:** response captured at edge r, retired at edge r+1 if at head.
- `wb_wb_en` is high for exactly one cycle per retire. `wb_dest`/`wb_value` hold their last values otherwise.
- `in_ready` and `hazard` are combinational from registered state only. They do not depend on `in_valid` or `mem_rsp_valid`.
- Sustained throughput is one result per cycle with no loads outstanding.

## Structure
- **Package `wb_pkg`:**
  - entry-state enum {EMPTY, WAIT_MEM, READY};
  - entry struct {state, wb_en, dest[3:0], is_load, s, flags[3:0], value[31:0]};
  - flag index constants N=3, Z=2, C=1, V=0.
- **Sub-module `retire_hazard_cmp`:** one instance per entry, comparing the entry against `hz_src1`/`hz_src2`. Its outputs are OR-reduced in the top level.

## Test plan
- Reset, then enqueue ALU {dest=3, value=0x0000_00AA, wb_en=1, s=1, flags=4'b0100} → next cycle `wb_wb_en`=1, `wb_dest`=3, `wb_value`=0xAA, `status`=4'b0100.
- Enqueue load dest=5, then ALU dest=6 value=7; respond 0xDEAD_BEEF three cycles later → `count` holds at 2 until the response. Then retires occur on consecutive cycles: (5, 0xDEADBEEF), then (6, 7).
- Enqueue DEPTH=4 loads with no responses → `in_ready`=0 and `count`=4; a fifth `in_valid` is ignored. A response frees one slot one cycle later.
- With a pending entry dest=9 wb_en=1: `hz_src1`=9 → `hazard`=1. With `hz_src2`=9 and `hz_two_src`=0 → `hazard`=0. After that entry retires → `hazard`=0.
- `mem_rsp_valid` with no loads pending → `rsp_err`=1 and remains 1. Next, enqueue a load, assert `rst_n`=0 mid-wait, release, then respond → queue stays empty and `wb_wb_en` never pulses.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the write-back retirement queue
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    READY    = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic         wb_en;
    logic [3:0]   dest;
    logic         is_load;
    logic         s;
    logic [3:0]   flags;
    logic [31:0]  value;
  } entry_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/retire_hazard_cmp.sv
// rtl/retire_hazard_cmp.sv - one queue entry's pending-write match against ID sources
module retire_hazard_cmp (
  input  logic       valid,
  input  logic       wb_en,
  input  logic [3:0] dest,
  input  logic [3:0] hz_src1,
  input  logic [3:0] hz_src2,
  input  logic       hz_two_src,
  output logic       hit
);

  assign hit = valid && wb_en &&
               ((dest == hz_src1) || (hz_two_src && (dest == hz_src2)));

endmodule

// File: rtl/wb_retire.sv
// rtl/wb_retire.sv - in-order write-back retirement queue with status register and hazard check
module wb_retire
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_wb_en,
  input  logic [3:0]                 in_dest,
  input  logic                       in_mem_read,
  input  logic [31:0]                in_value,
  input  logic                       in_s,
  input  logic [3:0]                 in_flags,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  input  logic [3:0]                 hz_src1,
  input  logic [3:0]                 hz_src2,
  input  logic                       hz_two_src,
  output logic                       hazard,
  output logic                       wb_wb_en,
  output logic [3:0]                 wb_dest,
  output logic [31:0]                wb_value,
  output logic [3:0]                 status,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       rsp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wb_wb_en_q, wb_wb_en_d;
  logic [3:0]      wb_dest_q, wb_dest_d;
  logic [31:0]     wb_value_q, wb_value_d;
  logic [3:0]      status_q, status_d;
  logic            rsp_err_q, rsp_err_d;

  logic            enq;
  logic            retire;
  logic            ld_found;
  logic [PW-1:0]   ld_idx;
  logic [PW-1:0]   scan_idx;
  logic [DEPTH-1:0] hits;

  assign in_ready = (count_q < CW'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign retire   = (ent_q[head_q].state == READY);

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    wb_wb_en_d = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_value_d = wb_value_q;
    status_d   = status_q;
    rsp_err_d  = rsp_err_q;
    ld_found   = 1'b0;
    ld_idx     = head_q;
    scan_idx   = head_q;

    // Loads complete in order, so the load pointer is the first WAIT_MEM entry from the head.
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!ld_found && ent_q[scan_idx].state == WAIT_MEM) begin
        ld_found = 1'b1;
        ld_idx   = scan_idx;
      end
    end

    if (retire) begin
      ent_d[head_q].state = EMPTY;
      head_d     = head_q + PW'(1);
      wb_wb_en_d = ent_q[head_q].wb_en;
      wb_dest_d  = ent_q[head_q].dest;
      wb_value_d = ent_q[head_q].value;
      if (ent_q[head_q].s && !ent_q[head_q].is_load) begin
        status_d = ent_q[head_q].flags;
      end
    end

    if (mem_rsp_valid) begin
      if (ld_found) begin
        ent_d[ld_idx].value = mem_rsp_data;
        ent_d[ld_idx].state = READY;
      end else begin
        rsp_err_d = 1'b1;
      end
    end

    if (enq) begin
      ent_d[tail_q] = '{
        state:   (in_mem_read ? WAIT_MEM : READY),
        wb_en:   in_wb_en,
        dest:    in_dest,
        is_load: in_mem_read,
        s:       in_s && !in_mem_read,
        flags:   in_flags,
        value:   (in_mem_read ? 32'd0 : in_value)
      };
      tail_d = tail_q + PW'(1);
    end

    count_d = count_q + CW'(enq) - CW'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wb_wb_en_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
      status_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wb_wb_en_q <= wb_wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_value_q <= wb_value_d;
      status_q   <= status_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // The retired output register is deliberately not compared: the register file already has it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    retire_hazard_cmp u_cmp (
      .valid      (ent_q[g].state != EMPTY),
      .wb_en      (ent_q[g].wb_en),
      .dest       (ent_q[g].dest),
      .hz_src1    (hz_src1),
      .hz_src2    (hz_src2),
      .hz_two_src (hz_two_src),
      .hit        (hits[g])
    );
  end

  assign hazard   = |hits;
  assign wb_wb_en = wb_wb_en_q;
  assign wb_dest  = wb_dest_q;
  assign wb_value = wb_value_q;
  assign status   = status_q;
  assign count    = count_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_wb_retire.sv
// tb/tb_wb_retire.sv - scoreboard bench for the write-back retirement queue
module tb_wb_retire;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wb_en = 1'b0;
  logic [3:0]  in_dest = '0;
  logic        in_mem_read = 1'b0;
  logic [31:0] in_value = '0;
  logic        in_s = 1'b0;
  logic [3:0]  in_flags = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [3:0]  hz_src1 = '0;
  logic [3:0]  hz_src2 = '0;
  logic        hz_two_src = 1'b0;
  logic        hazard;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  status;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic        rsp_err;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  wb_retire #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wb_en      (in_wb_en),
    .in_dest       (in_dest),
    .in_mem_read   (in_mem_read),
    .in_value      (in_value),
    .in_s          (in_s),
    .in_flags      (in_flags),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .hz_src1       (hz_src1),
    .hz_src2       (hz_src2),
    .hz_two_src    (hz_two_src),
    .hazard        (hazard),
    .wb_wb_en      (wb_wb_en),
    .wb_dest       (wb_dest),
    .wb_value      (wb_value),
    .status        (status),
    .count         (count),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wb_wb_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got strobe dest=%0d value=%h, expected no strobe", wb_dest, wb_value);
      end else begin
        mon_e = sb.pop_front();
        if (wb_dest !== mon_e.dest || wb_value !== mon_e.value) begin
          errors++;
          $display("FAIL sb_retire got dest=%0d value=%h, expected dest=%0d value=%h",
                   wb_dest, wb_value, mon_e.dest, mon_e.value);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic ld, input logic [3:0] dest, input logic [31:0] val,
                     input logic wb_en, input logic s, input logic [3:0] flags,
                     input logic [31:0] exp_val, input bit track);
    in_valid    = 1'b1;
    in_mem_read = ld;
    in_dest     = dest;
    in_value    = val;
    in_wb_en    = wb_en;
    in_s        = s;
    in_flags    = flags;
    if (in_ready && wb_en && track) sb.push_back('{dest: dest, value: exp_val});
    step();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (count !== 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL %s_drain got count=%0d, expected 0 within 50 cycles", name, count);
    end
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (wb_wb_en !== 1'b0 || count !== 0 || status !== 4'd0 || rsp_err !== 1'b0 ||
        in_ready !== 1'b1 || hazard !== 1'b0 || wb_dest !== 4'd0 || wb_value !== 32'd0) begin
      errors++;
      $display("FAIL reset got wb_en=%b count=%0d status=%b rsp_err=%b ready=%b hazard=%b dest=%0d value=%h, expected 0 0 0000 0 1 0 0 0",
               wb_wb_en, count, status, rsp_err, in_ready, hazard, wb_dest, wb_value);
    end
  endtask

  task automatic test_alu();
    enq(1'b0, 4'd3, 32'h0000_00AA, 1'b1, 1'b1, 4'b0100, 32'h0000_00AA, 1'b1);
    checks++;
    if (count !== 1 || wb_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_accept got count=%0d wb_en=%b, expected 1 0", count, wb_wb_en);
    end
    step();
    checks++;
    if (wb_wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_value !== 32'hAA || status !== 4'b0100 || count !== 0) begin
      errors++;
      $display("FAIL alu_retire got wb_en=%b dest=%0d value=%h status=%b count=%0d, expected 1 3 000000aa 0100 0",
               wb_wb_en, wb_dest, wb_value, status, count);
    end
    step();
    checks++;
    if (wb_wb_en !== 1'b0 || wb_dest !== 4'd3 || wb_value !== 32'hAA) begin
      errors++;
      $display("FAIL alu_hold got wb_en=%b dest=%0d value=%h, expected 0 3 000000aa", wb_wb_en, wb_dest, wb_value);
    end
  endtask

  task automatic test_load_order();
    enq(1'b1, 4'd5, 32'h1234_5678, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    enq(1'b0, 4'd6, 32'd7, 1'b1, 1'b0, 4'b0000, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count !== 2 || wb_wb_en !== 1'b0) begin
        errors++;
        $display("FAIL load_wait got count=%0d wb_en=%b, expected 2 0", count, wb_wb_en);
      end
      step();
    end
    respond(32'hDEAD_BEEF);
    checks++;
    if (count !== 2 || wb_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL load_capture got count=%0d wb_en=%b, expected 2 0", count, wb_wb_en);
    end
    step();
    checks++;
    if (wb_wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_value !== 32'hDEAD_BEEF || count !== 1) begin
      errors++;
      $display("FAIL load_retire got wb_en=%b dest=%0d value=%h count=%0d, expected 1 5 deadbeef 1",
               wb_wb_en, wb_dest, wb_value, count);
    end
    step();
    checks++;
    if (wb_wb_en !== 1'b1 || wb_dest !== 4'd6 || wb_value !== 32'd7 || count !== 0 || status !== 4'b0100) begin
      errors++;
      $display("FAIL load_follow got wb_en=%b dest=%0d value=%h count=%0d status=%b, expected 1 6 00000007 0 0100",
               wb_wb_en, wb_dest, wb_value, count, status);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      enq(1'b0, 4'(10 + i), 32'(i * 3 + 1), 1'b1, 1'b0, 4'b0000, 32'(i * 3 + 1), 1'b1);
      checks++;
      if (count !== 1) begin
        errors++;
        $display("FAIL b2b_count got count=%0d, expected 1", count);
      end
    end
    enq(1'b0, 4'd13, 32'h55, 1'b0, 1'b1, 4'b1011, 32'h55, 1'b1);
    checks++;
    if (count !== 1) begin
      errors++;
      $display("FAIL b2b_count got count=%0d, expected 1", count);
    end
    step();
    checks++;
    if (count !== 0 || wb_wb_en !== 1'b0 || status !== 4'b1011) begin
      errors++;
      $display("FAIL b2b_nowrite got count=%0d wb_en=%b status=%b, expected 0 0 1011", count, wb_wb_en, status);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) begin
      enq(1'b1, 4'(i), 32'd0, 1'b1, 1'b0, 4'b0000, 32'h100 + 32'(i), 1'b1);
    end
    checks++;
    if (count !== DEPTH || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state got count=%0d ready=%b, expected 4 0", count, in_ready);
    end
    enq(1'b0, 4'd14, 32'h999, 1'b1, 1'b0, 4'b0000, 32'h999, 1'b1);
    checks++;
    if (count !== DEPTH) begin
      errors++;
      $display("FAIL full_reject got count=%0d, expected 4", count);
    end
    respond(32'h101);
    checks++;
    if (count !== DEPTH || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_capture got count=%0d ready=%b, expected 4 0", count, in_ready);
    end
    step();
    checks++;
    if (count !== DEPTH - 1 || in_ready !== 1'b1 || wb_wb_en !== 1'b1 || wb_dest !== 4'd1) begin
      errors++;
      $display("FAIL full_free got count=%0d ready=%b wb_en=%b dest=%0d, expected 3 1 1 1",
               count, in_ready, wb_wb_en, wb_dest);
    end
    for (int i = 2; i <= DEPTH; i++) respond(32'h100 + 32'(i));
    wait_empty("full");
  endtask

  task automatic test_hazard();
    enq(1'b1, 4'd9, 32'd0, 1'b1, 1'b0, 4'b0000, 32'h0000_0909, 1'b1);
    hz_src1 = 4'd9; hz_src2 = 4'd0; hz_two_src = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL hz_src1 got hazard=%b, expected 1", hazard);
    end
    hz_src1 = 4'd0; hz_src2 = 4'd9;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL hz_src2_dead got hazard=%b, expected 0", hazard);
    end
    hz_two_src = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL hz_src2_live got hazard=%b, expected 1", hazard);
    end
    respond(32'h0000_0909);
    step();
    checks++;
    if (hazard !== 1'b0 || wb_wb_en !== 1'b1) begin
      errors++;
      $display("FAIL hz_retired got hazard=%b wb_en=%b, expected 0 1", hazard, wb_wb_en);
    end
    hz_src2 = 4'd0; hz_two_src = 1'b0;
    step();
  endtask

  task automatic test_rsp_err();
    respond(32'hBAD0_0001);
    checks++;
    if (rsp_err !== 1'b1 || count !== 0) begin
      errors++;
      $display("FAIL rsp_err_set got rsp_err=%b count=%0d, expected 1 0", rsp_err, count);
    end
    step(); step();
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL rsp_err_sticky got rsp_err=%b, expected 1", rsp_err);
    end
    enq(1'b1, 4'd8, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 0 || rsp_err !== 1'b0 || wb_wb_en !== 1'b0 || status !== 4'd0) begin
      errors++;
      $display("FAIL async_reset got count=%0d rsp_err=%b wb_en=%b status=%b, expected 0 0 0 0000",
               count, rsp_err, wb_wb_en, status);
    end
    step();
    rst_n = 1'b1;
    step();
    respond(32'hCAFE_F00D);
    checks++;
    if (rsp_err !== 1'b1 || count !== 0) begin
      errors++;
      $display("FAIL post_reset_rsp got rsp_err=%b count=%0d, expected 1 0", rsp_err, count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wb_wb_en !== 1'b0 || count !== 0) begin
        errors++;
        $display("FAIL post_reset_quiet got wb_en=%b count=%0d, expected 0 0", wb_wb_en, count);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    test_reset();
    test_alu();
    test_load_order();
    test_back_to_back();
    test_full();
    test_hazard();
    test_rsp_err();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d unretired results, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
